mem_1w1r_param_ext: RTL



---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_rd_pipe.sv | 45 ++++
 rtl/mem_1w1r_param_ext.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and elaboration helpers for the parametrised 1W1R memory model.
package mem_pkg;

    typedef enum logic {INIT, RUN} state_e;

    // Address width for a given depth, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int lane_count(input int dw, input int gran);
        return dw / gran;
    endfunction

    function automatic bit params_ok(input int dw, input int depth, input int aw,
                                     input int gran, input int lat);
        return (dw > 0) && (gran > 0) && (dw % gran == 0) && (depth >= 1) &&
               (aw >= 1) && ((64'd1 << aw) >= 64'(depth)) && (lat >= 1) && (lat <= 3);
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Extra read-latency stages; each stage only reloads data when its input is valid,
// so the output word holds its last value between read pulses.
module mem_rd_pipe #(
    parameter int DATA_WIDTH = 64,
    parameter int STAGES     = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_vld_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_vld_o,
    output logic [DATA_WIDTH-1:0] out_data_o
);

    if (STAGES == 0) begin : g_pass
        logic unused_clk;
        assign unused_clk = clock & reset_n;
        assign out_vld_o  = in_vld_i;
        assign out_data_o = in_data_i;
    end else begin : g_pipe
        logic [STAGES:1]                 vld_q;
        logic [STAGES:1][DATA_WIDTH-1:0] data_q;
        logic [STAGES:0]                 vld_pipe;
        logic [STAGES:0][DATA_WIDTH-1:0] data_pipe;

        assign vld_pipe  = {vld_q, in_vld_i};
        assign data_pipe = {data_q, in_data_i};

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                vld_q  <= '0;
                data_q <= '0;
            end else begin
                for (int s = 1; s <= STAGES; s++) begin
                    vld_q[s] <= vld_pipe[s-1];
                    if (vld_pipe[s-1]) data_q[s] <= data_pipe[s-1];
                end
            end
        end

        assign out_vld_o  = vld_pipe[STAGES];
        assign out_data_o = data_pipe[STAGES];
    end

endmodule

// File: rtl/mem_1w1r_param_ext.sv
// Parametrised one-write/one-read SRAM model with init sweep, masked writes,
// optional write-to-read bypass, pipelined read latency and sticky range error.
module mem_1w1r_param_ext
    import mem_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 64,
    parameter int                    DEPTH        = 512,
    parameter int                    ADDR_WIDTH   = clog2_min1(DEPTH),
    parameter int                    MASK_GRAN    = 8,
    parameter int                    READ_LATENCY = 1,
    parameter int                    BYPASS       = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            init_req,
    output logic                            init_done,
    input  logic                            W0_en,
    input  logic [ADDR_WIDTH-1:0]           W0_addr,
    input  logic [DATA_WIDTH-1:0]           W0_data,
    input  logic [DATA_WIDTH/MASK_GRAN-1:0] W0_mask,
    input  logic                            R0_en,
    input  logic [ADDR_WIDTH-1:0]           R0_addr,
    output logic [DATA_WIDTH-1:0]           R0_data,
    output logic                            R0_valid,
    output logic                            oob_err
);

    localparam int                    LANES     = lane_count(DATA_WIDTH, MASK_GRAN);
    localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    if (!params_ok(DATA_WIDTH, DEPTH, ADDR_WIDTH, MASK_GRAN, READ_LATENCY)) begin : g_bad_params
        $error("mem_1w1r_param_ext: illegal parameter combination");
    end

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  oob_q, oob_d;
    logic                  rd_vld_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  run, wr_oob, rd_oob, wr_ok, rd_ok;

    logic [DATA_WIDTH-1:0] ram [DEPTH];

    assign run    = (state_q == RUN);
    assign wr_oob = ({1'b0, W0_addr} >= DEPTH_X);
    assign rd_oob = ({1'b0, R0_addr} >= DEPTH_X);
    assign wr_ok  = run & W0_en & ~wr_oob;
    assign rd_ok  = run & R0_en;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (init_req) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = INIT;
        endcase
    end

    assign oob_d = oob_q | (run & ((W0_en & wr_oob) | (R0_en & rd_oob)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            oob_q   <= oob_d;
        end
    end

    // Array contents survive reset; only the sweep rewrites them.
    always_ff @(posedge clock) begin
        if (state_q == INIT) begin
            ram[cnt_q] <= INIT_VALUE;
        end else if (wr_ok) begin
            for (int k = 0; k < LANES; k++) begin
                if (W0_mask[k])
                    ram[W0_addr][k*MASK_GRAN +: MASK_GRAN] <= W0_data[k*MASK_GRAN +: MASK_GRAN];
            end
        end
    end

    always_comb begin
        rd_word = INIT_VALUE;
        if (!rd_oob) rd_word = ram[R0_addr];
        if ((BYPASS != 0) && wr_ok && (W0_addr == R0_addr)) begin
            for (int k = 0; k < LANES; k++) begin
                if (W0_mask[k])
                    rd_word[k*MASK_GRAN +: MASK_GRAN] = W0_data[k*MASK_GRAN +: MASK_GRAN];
            end
        end
    end

    // First read stage lives here; the sub-module adds the remaining latency.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_vld_q <= rd_ok;
            if (rd_ok) rd_data_q <= rd_word;
        end
    end

    mem_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .STAGES     (READ_LATENCY - 1)
    ) u_rd_pipe (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_vld_i   (rd_vld_q),
        .in_data_i  (rd_data_q),
        .out_vld_o  (R0_valid),
        .out_data_o (R0_data)
    );

    assign init_done = run;
    assign oob_err   = oob_q;

endmodule
